ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage. It holds the architectural fetch PC and looks each PC up in a direct-mapped instruction cache. On a hit it pushes {instruction, PC} into the instruction queue, at most one per cycle. On a miss it fills the line through the memory controller, and on a ROB flush it redirects to the flush target PC. Branch prediction is static: the next PC is always PC+4.

## Interface

Parameters:
- ICACHE_LINES, 256: number of one-word cache lines; power of two.
- RESET_PC, 32'h0: PC loaded at reset.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  global stall-free enable; when low, all state holds.
- rob_flush_in  input  1  mispredict/exception flush.
- rob_pc_in  input  32  redirect PC, valid when rob_flush_in is high.
- instqueue_rdy_in  input  1  instruction queue can accept one more entry beyond any entry currently presented.
- instqueue_en_out  output  1  one-cycle push strobe.
- instqueue_inst_out  output  32  fetched instruction.
- instqueue_pc_out  output  32  PC of that instruction.
- memctrl_en_out  output  1  fill request; held high until done or aborted.
- memctrl_addr_out  output  32  word-aligned fill address.
- memctrl_done_in  input  1  fill complete; asserted only while memctrl_en_out is high.
- memctrl_inst_in  input  32  fill data, valid with memctrl_done_in.

## Operation

Address split, with IW = log2(ICACHE_LINES):
- index = pc[IW+1:2]
- tag = pc[31:IW+2]
- pc[1:0] is ignored.

Per line state: valid bit, tag, 32-bit data.

State machine has two states, IDLE and MISS.

IDLE, when rdy_in is high and rob_flush_in is low:
- If instqueue_rdy_in is low: no action.
- Hit (valid[index] and tag matches): instqueue_en_out<=1, instqueue_inst_out<=data[index], instqueue_pc_out<=pc, pc<=pc+4 (32-bit wraparound).
- Miss: memctrl_en_out<=1, memctrl_addr_out<={pc[31:2],2'b00}, state<=MISS. PC is unchanged.

MISS, when rdy_in is high and rob_flush_in is low:
- Hold memctrl_en_out and memctrl_addr_out.
- When memctrl_done_in is high: write data, tag and valid for the line at memctrl_addr_out; set memctrl_en_out<=0 and state<=IDLE.
- The filled instruction is not forwarded. The next IDLE cycle re-looks up and hits.

Flush (rob_flush_in high with rdy_in high, in any state; highest priority):
- pc<=rob_pc_in, state<=IDLE, memctrl_en_out<=0, instqueue_en_out<=0.
- Dropping memctrl_en_out aborts the outstanding fill.
- If memctrl_done_in coincides with the flush, the fill still writes the cache, because the data is correct for the latched address.
- Cache contents are never invalidated by a flush.

Defaults:
- instqueue_en_out defaults to 0 every cycle unless set by a hit. It is therefore never high for two cycles on the same entry.
- When rdy_in is low: instqueue_en_out<=0 and all other state holds, including memctrl_en_out.

Reset (rst_in high at a clock edge, overriding everything):
- pc<=RESET_PC, state<=IDLE, all valid bits<=0.
- instqueue_en_out, instqueue_inst_out, instqueue_pc_out, memctrl_en_out, memctrl_addr_out all <=0.
- Reset in MISS abandons the fill with no cache write.

## Timing

- All outputs are registered, with no combinational paths from input to output.
- Hit latency: a hit looked up in cycle t presents instqueue_en_out in cycle t+1.
- Sustained throughput: 1 instruction/cycle while hits continue and instqueue_rdy_in stays high.
- Miss latency: a miss looked up in cycle t raises memctrl_en_out in t+1. If memctrl_done_in arrives in cycle t+1+N, state is IDLE in t+2+N and the hit is pushed in t+3+N.
- Flush sampled in cycle t: a lookup of rob_pc_in occurs in t+1. The earliest push of the target is in t+2. No stale push appears after the flush cycle.
- Cache read is combinational (LUT-RAM style). The cache write on fill takes effect at the clock edge.

## Test plan

1. Reset with RESET_PC=0 and memory holding word k at 4k, instqueue_rdy_in=1, memctrl_done_in returned 3 cycles after each request.
   - Required: requests to 0x0, 0x4, 0x8 in order.
   - Required: pushes (pc, inst)=(0,w0), (4,w1), (8,w2), each 2 cycles after the corresponding done.
2. Warm cache lines for 0x0–0xC, flush to 0x0.
   - Required: four pushes on four consecutive cycles.
   - Required: memctrl_en_out stays low.
3. Warm hits with instqueue_rdy_in low for 5 cycles mid-stream.
   - Required: no pushes and no PC advance during the 5 cycles.
   - Required: the stream resumes at the next PC with no skip and no duplicate.
4. Flush to 0x100 during MISS for 0x20, before done.
   - Required: memctrl_en_out drops the next cycle.
   - Required: the next request address is 0x100.
   - Required: no push with pc=0x20.
5. Flush coincident with memctrl_done_in for 0x40.
   - Required: the line for 0x40 is valid afterwards (a later fetch of 0x40 hits with no request).
   - Required: the PC becomes the flush target.
6. With ICACHE_LINES=256, fetch 0x0 then 0x400 (same index), then 0x0 again.
   - Required: the third fetch misses and issues a request to 0x0.

Source files
------------

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-queue push port and memory-controller fill port.
// Member names keep the fetch stage's point of view; master is the fetch side.
interface ifetch_if;
    logic        instqueue_rdy_in;
    logic        instqueue_en_out;
    logic [31:0] instqueue_inst_out;
    logic [31:0] instqueue_pc_out;
    logic        memctrl_en_out;
    logic [31:0] memctrl_addr_out;
    logic        memctrl_done_in;
    logic [31:0] memctrl_inst_in;

    modport master (
        input  instqueue_rdy_in,
        input  memctrl_done_in,
        input  memctrl_inst_in,
        output instqueue_en_out,
        output instqueue_inst_out,
        output instqueue_pc_out,
        output memctrl_en_out,
        output memctrl_addr_out
    );

    modport slave (
        output instqueue_rdy_in,
        output memctrl_done_in,
        output memctrl_inst_in,
        input  instqueue_en_out,
        input  instqueue_inst_out,
        input  instqueue_pc_out,
        input  memctrl_en_out,
        input  memctrl_addr_out
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: direct-mapped one-word-per-line icache, PC+4 static prediction,
// line fill through the memory controller and redirect on ROB flush.
module ifetch #(
    parameter int unsigned ICACHE_LINES = 256,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_flush_in,
    input  logic [31:0] rob_pc_in,
    ifetch_if.master    bus
);
    localparam int unsigned IW = $clog2(ICACHE_LINES);
    localparam int unsigned TW = 30 - IW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MISS = 1'b1;

    logic [0:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        iq_en, iq_en_nxt;
    logic [31:0] iq_inst, iq_inst_nxt;
    logic [31:0] iq_pc, iq_pc_nxt;
    logic        mem_en, mem_en_nxt;
    logic [31:0] mem_addr, mem_addr_nxt;

    logic [ICACHE_LINES-1:0] valid;
    logic [TW-1:0]           tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];

    logic [IW-1:0] idx_c;
    logic [TW-1:0] tag_c;
    logic          hit_c;
    logic [IW-1:0] fill_idx_c;
    logic [TW-1:0] fill_tag_c;
    logic          fill_we_c;

    // Combinational lookup of the current PC and fill address split.
    always_comb begin
        idx_c      = pc[IW+1:2];
        tag_c      = pc[31:IW+2];
        hit_c      = valid[idx_c] && (tag_mem[idx_c] == tag_c);
        fill_idx_c = mem_addr[IW+1:2];
        fill_tag_c = mem_addr[31:IW+2];
        // A fill completing alongside a flush still lands: the data matches the latched address.
        fill_we_c  = rdy_in && (state == MISS) && bus.memctrl_done_in;
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        iq_en_nxt    = 1'b0;
        iq_inst_nxt  = iq_inst;
        iq_pc_nxt    = iq_pc;
        mem_en_nxt   = mem_en;
        mem_addr_nxt = mem_addr;
        if (rdy_in) begin
            if (rob_flush_in) begin
                pc_nxt     = rob_pc_in;
                state_nxt  = IDLE;
                mem_en_nxt = 1'b0;
            end else if (state == IDLE) begin
                if (bus.instqueue_rdy_in) begin
                    if (hit_c) begin
                        iq_en_nxt   = 1'b1;
                        iq_inst_nxt = data_mem[idx_c];
                        iq_pc_nxt   = pc;
                        pc_nxt      = pc + 32'd4;
                    end else begin
                        mem_en_nxt   = 1'b1;
                        mem_addr_nxt = {pc[31:2], 2'b00};
                        state_nxt    = MISS;
                    end
                end
            end else if (bus.memctrl_done_in) begin
                mem_en_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            iq_en    <= 1'b0;
            iq_inst  <= 32'h0;
            iq_pc    <= 32'h0;
            mem_en   <= 1'b0;
            mem_addr <= 32'h0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            iq_en    <= iq_en_nxt;
            iq_inst  <= iq_inst_nxt;
            iq_pc    <= iq_pc_nxt;
            mem_en   <= mem_en_nxt;
            mem_addr <= mem_addr_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (fill_we_c) begin
            valid[fill_idx_c] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_in) begin
        if (!rst_in && fill_we_c) begin
            tag_mem[fill_idx_c]  <= fill_tag_c;
            data_mem[fill_idx_c] <= bus.memctrl_inst_in;
        end
    end

    assign bus.instqueue_en_out   = iq_en;
    assign bus.instqueue_inst_out = iq_inst;
    assign bus.instqueue_pc_out   = iq_pc;
    assign bus.memctrl_en_out     = mem_en;
    assign bus.memctrl_addr_out   = mem_addr;
endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a memory-controller responder model plus expected
// push/request queues filled as stimulus is driven and drained as the DUT responds.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_flush;
    logic [31:0] rob_pc;

    ifetch_if bus ();

    ifetch #(.ICACHE_LINES(256), .RESET_PC(32'h0)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .rob_flush_in (rob_flush),
        .rob_pc_in    (rob_pc),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } push_t;

    push_t       exp_push_q [$];
    logic [31:0] exp_req_q  [$];
    int          push_cyc_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int npush    = 0;
    int nreq     = 0;
    int en_cyc   = 0;
    int done_cyc = 0;
    int lat      = 3;
    int rcnt     = 0;
    bit check_lat = 1'b0;
    logic en_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1357_0000 + 32'(a[31:2]);
    endfunction

    task automatic expect_push(input logic [31:0] pc);
        push_t p;
        p.pc   = pc;
        p.inst = mem_word(pc);
        exp_push_q.push_back(p);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory controller: raises done 'lat' cycles after the request is seen, aborts if en drops.
    always @(negedge clk) begin
        if (bus.memctrl_done_in) begin
            bus.memctrl_done_in = 1'b0;
            rcnt = 0;
        end else if (bus.memctrl_en_out && !rst) begin
            if (rcnt == lat) begin
                bus.memctrl_done_in = 1'b1;
                bus.memctrl_inst_in = mem_word(bus.memctrl_addr_out);
                done_cyc = cyc;
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
    end

    // Output monitor, sampled just after each active edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (bus.instqueue_en_out) begin
                push_t p;
                npush++;
                push_cyc_q.push_back(cyc);
                check_eq("push_expected", 32'(exp_push_q.size() != 0), 32'd1);
                if (exp_push_q.size() != 0) begin
                    p = exp_push_q.pop_front();
                    check_eq("push_pc", bus.instqueue_pc_out, p.pc);
                    check_eq("push_inst", bus.instqueue_inst_out, p.inst);
                    if (check_lat) check_eq("push_latency", 32'(cyc - done_cyc), 32'd2);
                end
            end
            if (bus.memctrl_en_out) en_cyc++;
            if (bus.memctrl_en_out && !en_prev) begin
                nreq++;
                check_eq("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
                if (exp_req_q.size() != 0) check_eq("req_addr", bus.memctrl_addr_out, exp_req_q.pop_front());
            end
        end
        en_prev = bus.memctrl_en_out;
    end

    task automatic wait_push(input int target);
        int n = 0;
        while (npush < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (npush < target) check_eq("timeout_push", 32'(npush), 32'(target));
    endtask

    task automatic flush_to(input logic [31:0] pc);
        @(negedge clk);
        rob_flush = 1'b1;
        rob_pc    = pc;
        bus.instqueue_rdy_in = 1'b1;
        @(negedge clk);
        rob_flush = 1'b0;
    endtask

    initial begin
        int p0;
        int n;
        rst = 1'b1;
        rdy = 1'b1;
        rob_flush = 1'b0;
        rob_pc = 32'h0;
        bus.instqueue_rdy_in = 1'b1;
        bus.memctrl_done_in  = 1'b0;
        bus.memctrl_inst_in  = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_iq_en", 32'(bus.instqueue_en_out), 32'd0);
        check_eq("rst_iq_inst", bus.instqueue_inst_out, 32'h0);
        check_eq("rst_iq_pc", bus.instqueue_pc_out, 32'h0);
        check_eq("rst_mem_en", 32'(bus.memctrl_en_out), 32'd0);
        check_eq("rst_mem_addr", bus.memctrl_addr_out, 32'h0);

        // Cold start: three misses, each pushed two cycles after its fill completes.
        for (int i = 0; i < 3; i++) begin
            exp_req_q.push_back(32'(4 * i));
            expect_push(32'(4 * i));
        end
        check_lat = 1'b1;
        rst = 1'b0;
        wait_push(3);
        bus.instqueue_rdy_in = 1'b0;
        check_lat = 1'b0;

        // Warm 0xC, then a flush to 0 must stream four hits back to back.
        exp_req_q.push_back(32'hC);
        expect_push(32'hC);
        bus.instqueue_rdy_in = 1'b1;
        wait_push(4);
        bus.instqueue_rdy_in = 1'b0;
        n = en_cyc;
        p0 = npush;
        for (int i = 0; i < 4; i++) expect_push(32'(4 * i));
        flush_to(32'h0);
        wait_push(p0 + 4);
        bus.instqueue_rdy_in = 1'b0;
        check_eq("burst_span", 32'(push_cyc_q[push_cyc_q.size()-1] - push_cyc_q[push_cyc_q.size()-4]), 32'd3);
        check_eq("burst_no_memen", 32'(en_cyc - n), 32'd0);

        // Queue back-pressure for 5 cycles mid-stream.
        p0 = npush;
        for (int i = 0; i < 4; i++) expect_push(32'(4 * i));
        flush_to(32'h0);
        wait_push(p0 + 2);
        bus.instqueue_rdy_in = 1'b0;
        p0 = npush;
        repeat (5) @(negedge clk);
        check_eq("stall_no_push", 32'(npush - p0), 32'd0);
        bus.instqueue_rdy_in = 1'b1;
        wait_push(p0 + 2);
        bus.instqueue_rdy_in = 1'b0;

        // Flush during a miss aborts the fill and redirects.
        lat = 6;
        exp_req_q.push_back(32'h20);
        flush_to(32'h20);
        n = 0;
        while (!bus.memctrl_en_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_req_seen", 32'(bus.memctrl_en_out), 32'd1);
        @(negedge clk);
        exp_req_q.push_back(32'h100);
        expect_push(32'h100);
        p0 = npush;
        rob_flush = 1'b1;
        rob_pc = 32'h100;
        @(posedge clk);
        #1;
        check_eq("t4_en_drop", 32'(bus.memctrl_en_out), 32'd0);
        @(negedge clk);
        rob_flush = 1'b0;
        wait_push(p0 + 1);
        bus.instqueue_rdy_in = 1'b0;
        lat = 3;

        // Flush coincident with done: fill still lands, PC goes to the target.
        exp_req_q.push_back(32'h40);
        flush_to(32'h40);
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            n++;
            if (bus.memctrl_done_in || n >= 50) break;
        end
        check_eq("t5_done_seen", 32'(bus.memctrl_done_in), 32'd1);
        exp_req_q.push_back(32'h200);
        expect_push(32'h200);
        p0 = npush;
        rob_flush = 1'b1;
        rob_pc = 32'h200;
        @(negedge clk);
        rob_flush = 1'b0;
        wait_push(p0 + 1);
        bus.instqueue_rdy_in = 1'b0;
        n = nreq;
        p0 = npush;
        expect_push(32'h40);
        flush_to(32'h40);
        wait_push(p0 + 1);
        bus.instqueue_rdy_in = 1'b0;
        check_eq("t5_line_valid", 32'(nreq - n), 32'd0);

        // Conflict on index 0: 0x0 hit, 0x400 evicts it, 0x0 misses again.
        n = nreq;
        p0 = npush;
        expect_push(32'h0);
        flush_to(32'h0);
        wait_push(p0 + 1);
        bus.instqueue_rdy_in = 1'b0;
        exp_req_q.push_back(32'h400);
        expect_push(32'h400);
        flush_to(32'h400);
        wait_push(p0 + 2);
        bus.instqueue_rdy_in = 1'b0;
        exp_req_q.push_back(32'h0);
        expect_push(32'h0);
        flush_to(32'h0);
        wait_push(p0 + 3);
        bus.instqueue_rdy_in = 1'b0;
        check_eq("t6_req_count", 32'(nreq - n), 32'd2);

        repeat (5) @(negedge clk);
        check_eq("push_q_drained", 32'(exp_push_q.size()), 32'd0);
        check_eq("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
